// File: rtl/sub_seq_pkg.sv
// Shared definitions for the sequential 32-bit subtractor.
//   state_t         : controller states (IDLE, CALC, DONE)
//   DATA_W          : operand/result width
//   SLICE_W_DEFAULT : default number of difference bits produced per cycle
package sub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W          = 32;
    localparam int SLICE_W_DEFAULT = 8;

endpackage

// File: rtl/sub_slice.sv
// Combinational SLICE_W-bit subtract slice: diff = a - b - borrow_in.
// Ports:
//   a, b       : slice operands
//   borrow_in  : borrow from the next-lower slice
//   diff       : slice difference, modulo 2^SLICE_W
//   borrow_out : set when a < b + borrow_in
module sub_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               borrow_in,
    output logic [SLICE_W-1:0] diff,
    output logic               borrow_out
);

    logic [SLICE_W:0] full;

    // Zero-extending by one bit makes the top bit of the result the borrow.
    assign full = {1'b0, a} - {1'b0, b} - {{SLICE_W{1'b0}}, borrow_in};
    assign {borrow_out, diff} = full;

endmodule

// File: rtl/sub_seq32bit.sv
// Sequential 32-bit subtractor: computes op1 - op2 - bin one SLICE_W-bit
// slice per cycle (LSB first) through a single reused sub_slice.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   op1, op2, bin       : minuend, subtrahend, borrow-in (taken on accept)
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   diff, bout, ovf     : result, unsigned borrow-out, signed overflow
//   out_valid/out_ready : result handshake (valid only in DONE)
module sub_seq32bit
    import sub_seq_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic              bin,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] diff,
    output logic              bout,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  op1_q;
    logic [DATA_W-1:0]  op2_q;
    logic               borrow_q;
    logic               sign1_q;
    logic               sign2_q;
    logic [DATA_W-1:0]  diff_q;
    logic               bout_q;
    logic               ovf_q;
    logic [SLICE_W-1:0] slice_diff;
    logic               slice_borrow;

    // Operands are shifted right each CALC cycle, so the slice always works
    // on the low bits and no variable part-select is needed.
    sub_slice #(
        .SLICE_W(SLICE_W)
    ) u_slice (
        .a         (op1_q[SLICE_W-1:0]),
        .b         (op2_q[SLICE_W-1:0]),
        .borrow_in (borrow_q),
        .diff      (slice_diff),
        .borrow_out(slice_borrow)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, run NSLICE cycles, hold until taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)        state_next = CALC;
            CALC:    if (cnt == LAST_CNT) state_next = DONE;
            DONE:    if (out_ready)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // Datapath. The operand sign bits are kept aside because the shifted
    // operand registers no longer hold them when the overflow is resolved.
    // The result is shifted in from the top so it ends up LSB-aligned after
    // the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            borrow_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op1_q    <= op1;
                        op2_q    <= op2;
                        borrow_q <= bin;
                        sign1_q  <= op1[DATA_W-1];
                        sign2_q  <= op2[DATA_W-1];
                        cnt      <= '0;
                        diff_q   <= '0;
                    end
                end
                CALC: begin
                    op1_q    <= {{SLICE_W{1'b0}}, op1_q[DATA_W-1:SLICE_W]};
                    op2_q    <= {{SLICE_W{1'b0}}, op2_q[DATA_W-1:SLICE_W]};
                    borrow_q <= slice_borrow;
                    diff_q   <= {slice_diff, diff_q[DATA_W-1:SLICE_W]};
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        bout_q <= slice_borrow;
                        ovf_q  <= (sign1_q != sign2_q) &&
                                  (slice_diff[SLICE_W-1] != sign1_q);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub_seq32bit.sv
// Directed self-checking bench for sub_seq32bit (default SLICE_W = 8).
module tb_sub_seq32bit;

    localparam int LATENCY = 4;
    localparam int TIMEOUT = 20;

    logic        clk;
    logic        rst_n;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        out_valid;
    logic        out_ready;

    int tests_run;
    int tests_failed;

    sub_seq32bit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op1      (op1),
        .op2      (op2),
        .bin      (bin),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .diff     (diff),
        .bout     (bout),
        .ovf      (ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, observed, expected);
        end
    endtask

    // Waits (bounded) for in_ready, then presents operands for one edge.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic [31:0] b, input logic bi);
        int waited;
        waited = 0;
        while (!in_ready && waited < TIMEOUT) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        op1      = a;
        op2      = b;
        bin      = bi;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op1      = 32'hA5A5_5A5A;
        op2      = 32'h5A5A_A5A5;
        bin      = 1'b1;
    endtask

    // Counts edges until out_valid (bounded); returns the count.
    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic takeResult(input string tag, input logic [31:0] exp_diff);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, " out_valid after take"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " in_ready after take"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " diff kept after take"}, diff, exp_diff);
    endtask

    task automatic runOp(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic bi,
                         input logic [31:0] exp_diff, input logic exp_bout,
                         input logic exp_ovf);
        int lat;
        applyStimulus(tag, a, b, bi);
        waitResult(lat);
        checkOutput({tag, " latency"}, 32'(lat), 32'(LATENCY));
        checkOutput({tag, " diff"}, diff, exp_diff);
        checkOutput({tag, " bout"}, 32'(bout), 32'(exp_bout));
        checkOutput({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        takeResult(tag, exp_diff);
    endtask

    initial begin
        int lat;
        int spurious;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        op1          = '0;
        op2          = '0;
        bin          = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;

        // Reset state.
        #23;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset diff", diff, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset bout", 32'(bout), 32'd0);
        checkOutput("reset ovf", 32'(ovf), 32'd0);

        // out_ready while idle has no effect.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("idle out_ready in_ready", 32'(in_ready), 32'd1);
        checkOutput("idle out_ready out_valid", 32'(out_valid), 32'd0);

        // Main function vectors.
        runOp("5-3", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
        runOp("0-1", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        runOp("min-1", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        runOp("hi-lo-bin", 32'hFFFF_0000, 32'h0000_FFFF, 1'b1,
              32'hFFFE_0000, 1'b0, 1'b0);
        runOp("max-neg1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0,
              32'h8000_0000, 1'b1, 1'b1);

        // Borrow ripple across every bit position.
        for (int i = 0; i < 32; i++) begin
            applyStimulus($sformatf("walk%0d", i), 32'd1 << i, 32'd1 << i, 1'b1);
            waitResult(lat);
            checkOutput($sformatf("walk%0d diff", i), diff, 32'hFFFF_FFFF);
            checkOutput($sformatf("walk%0d bout", i), 32'(bout), 32'd1);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end

        // Stall in DONE with a competing request.
        applyStimulus("stall", 32'h1234_5678, 32'h1111_1111, 1'b0);
        waitResult(lat);
        checkOutput("stall latency", 32'(lat), 32'(LATENCY));
        in_valid = 1'b1;
        op1      = 32'hDEAD_BEEF;
        op2      = 32'h0000_0001;
        bin      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("stall%0d out_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'd0);
            checkOutput($sformatf("stall%0d diff", i), diff, 32'h0123_4567);
        end
        in_valid = 1'b0;
        takeResult("stall", 32'h0123_4567);
        // The competing operands must not have started an operation.
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        checkOutput("stall no extra result", 32'(spurious), 32'd0);

        // Reset in the second CALC cycle aborts the operation.
        applyStimulus("abort", 32'hFFFF_FFFF, 32'd0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort diff", diff, 32'd0);
        #3;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        checkOutput("abort no result", 32'(spurious), 32'd0);
        checkOutput("abort in_ready", 32'(in_ready), 32'd1);
        runOp("post-abort", 32'd9, 32'd4, 1'b0, 32'h0000_0005, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
